// File: rtl/reg_writeback_unit.sv
// Register-file writeback controller: ALU results pass through in one cycle,
// and loads run an Avalon-MM read before the formatted data is written back.
// Optional LWL/LWR merge support is compiled in with `define UNALIGNED_LOAD_EN.
module reg_writeback_unit #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_is_load,
  input  logic [2:0]    req_ltype,
  input  logic [4:0]    req_rd,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_alu,
  input  logic [DW-1:0] req_old,
  output logic [AW-1:0] avm_address,
  output logic          avm_read,
  output logic [3:0]    avm_byteenable,
  input  logic          avm_waitrequest,
  input  logic [DW-1:0] avm_readdata,
  output logic          RegWrite,
  output logic [4:0]    writeR,
  output logic [DW-1:0] writedata,
  output logic          err
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both 1; req_ready is registered and only high in IDLE.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;
  localparam logic [2:0] LT_LWL = 3'd5;
  localparam logic [2:0] LT_LWR = 3'd6;

  state_t      state;
  logic [4:0]  rd_q;
  logic [2:0]  lt_q;
  logic [1:0]  k_q;
  logic [31:0] word_q;
  logic        accept;

`ifdef UNALIGNED_LOAD_EN
  logic [31:0] old_q;
`else
  logic        unused_old;
  assign unused_old = ^req_old;
`endif

  assign accept = req_valid & req_ready;

  function automatic logic load_legal(input logic [2:0] lt, input logic [1:0] a);
    case (lt)
      LT_LW:          load_legal = (a == 2'b00);
      LT_LB, LT_LBU:  load_legal = 1'b1;
      LT_LH, LT_LHU:  load_legal = ~a[0];
`ifdef UNALIGNED_LOAD_EN
      LT_LWL, LT_LWR: load_legal = 1'b1;
`endif
      default:        load_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lanes(input logic [2:0] lt, input logic [1:0] k);
    case (lt)
      LT_LW, LT_LWL, LT_LWR: lanes = 4'b1111;
      LT_LB, LT_LBU:         lanes = 4'b0001 << k;
      LT_LH, LT_LHU:         lanes = 4'b0011 << k;
      default:               lanes = 4'b0000;
    endcase
  endfunction

  // Little-endian extraction: lane k sits at bits 8k+7:8k.
  function automatic logic [31:0] base_fmt(input logic [2:0] lt, input logic [1:0] k,
                                           input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {k, 3'b000};
    case (lt)
      LT_LB:   base_fmt = {{24{shifted[7]}}, shifted[7:0]};
      LT_LBU:  base_fmt = {24'h0, shifted[7:0]};
      LT_LH:   base_fmt = {{16{shifted[15]}}, shifted[15:0]};
      LT_LHU:  base_fmt = {16'h0, shifted[15:0]};
      default: base_fmt = word;
    endcase
  endfunction

`ifdef UNALIGNED_LOAD_EN
  // 3-k equals ~k for a 2-bit k, so the LWL shift is 8*(~k).
  function automatic logic [31:0] merge_fmt(input logic [2:0] lt, input logic [1:0] k,
                                            input logic [31:0] word, input logic [31:0] old);
    logic [4:0] sh_l;
    logic [4:0] sh_r;
    sh_l = {~k, 3'b000};
    sh_r = {k, 3'b000};
    case (lt)
      LT_LWL:  merge_fmt = (word << sh_l) | (old & ~(32'hFFFF_FFFF << sh_l));
      LT_LWR:  merge_fmt = (word >> sh_r) | (old & ~(32'hFFFF_FFFF >> sh_r));
      default: merge_fmt = base_fmt(lt, k, word);
    endcase
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_ready      <= 1'b0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_byteenable <= 4'b0000;
      RegWrite       <= 1'b0;
      writeR         <= 5'd0;
      writedata      <= '0;
      err            <= 1'b0;
      rd_q           <= 5'd0;
      lt_q           <= 3'd0;
      k_q            <= 2'd0;
      word_q         <= 32'h0;
`ifdef UNALIGNED_LOAD_EN
      old_q          <= 32'h0;
`endif
    end else begin
      RegWrite <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            if (!req_is_load) begin
              // Writes to $0 are suppressed at the enable, not the address.
              RegWrite  <= (req_rd != 5'd0);
              writeR    <= req_rd;
              writedata <= req_alu;
            end else begin
              rd_q <= req_rd;
              lt_q <= req_ltype;
              k_q  <= req_addr[1:0];
`ifdef UNALIGNED_LOAD_EN
              old_q <= req_old;
`endif
              if (load_legal(req_ltype, req_addr[1:0])) begin
                state          <= READ;
                req_ready      <= 1'b0;
                avm_read       <= 1'b1;
                avm_address    <= {req_addr[AW-1:2], 2'b00};
                avm_byteenable <= lanes(req_ltype, req_addr[1:0]);
              end else begin
                err <= 1'b1;
              end
            end
          end
        end
        READ: begin
          if (!avm_waitrequest) begin
            word_q   <= avm_readdata;
            avm_read <= 1'b0;
            state    <= WB;
          end
        end
        WB: begin
          RegWrite  <= (rd_q != 5'd0);
          writeR    <= rd_q;
`ifdef UNALIGNED_LOAD_EN
          writedata <= merge_fmt(lt_q, k_q, word_q, old_q);
`else
          writedata <= base_fmt(lt_q, k_q, word_q);
`endif
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          avm_read  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed plus randomized bench for reg_writeback_unit with a slave model
// driving waitrequest/readdata and a reference model of load formatting.
module tb_reg_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_load;
  logic [2:0]  req_ltype;
  logic [4:0]  req_rd;
  logic [31:0] req_addr;
  logic [31:0] req_alu;
  logic [31:0] req_old;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        RegWrite;
  logic [4:0]  writeR;
  logic [31:0] writedata;
  logic        err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  reg_writeback_unit #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_load(req_is_load),
    .req_ltype(req_ltype), .req_rd(req_rd), .req_addr(req_addr),
    .req_alu(req_alu), .req_old(req_old),
    .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .RegWrite(RegWrite), .writeR(writeR), .writedata(writedata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: alignment size per type (0 = never legal).
  function automatic int model_size(input int lt);
    case (lt)
      0: return 4;
      1, 2: return 1;
      3, 4: return 2;
`ifdef UNALIGNED_LOAD_EN
      5, 6: return 1;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic bit model_legal(input int lt, input logic [31:0] addr);
    int sz;
    sz = model_size(lt);
    return (sz != 0) && ((addr % sz) == 0);
  endfunction

  function automatic logic [3:0] model_be(input int lt, input logic [31:0] addr);
    int k;
    k = addr % 4;
    if (lt == 0 || lt == 5 || lt == 6) return 4'hF;
    return 4'(((1 << model_size(lt)) - 1) << k);
  endfunction

  function automatic logic [31:0] model_data(input int lt, input logic [31:0] addr,
                                             input logic [31:0] word, input logic [31:0] old);
    int k;
    logic [31:0] b;
    logic [31:0] h;
    k = addr % 4;
    b = (word >> (8 * k)) & 32'hFF;
    h = (word >> (8 * k)) & 32'hFFFF;
    case (lt)
      1: return (b >= 128) ? b - 32'd256 : b;
      2: return b;
      3: return (h >= 32768) ? h - 32'd65536 : h;
      4: return h;
      5: return (word << (8 * (3 - k))) | (old & ~(32'hFFFF_FFFF << (8 * (3 - k))));
      6: return (word >> (8 * k)) | (old & ~(32'hFFFF_FFFF >> (8 * k)));
      default: return word;
    endcase
  endfunction

  // Called #1 after a rising edge; leaves the bench at #1 after the edge where the
  // ALU write becomes visible. Request stays driven for back-to-back use.
  task automatic do_alu(input logic [4:0] rd, input logic [31:0] data);
    req_valid   = 1'b1;
    req_is_load = 1'b0;
    req_rd      = rd;
    req_alu     = data;
    req_addr    = $urandom;
    req_ltype   = 3'($urandom_range(0, 7));
    check("alu_ready_before", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("alu_regwrite", 32'(RegWrite), 32'(rd != 5'd0));
    if (rd != 5'd0) begin
      check("alu_writer", 32'(writeR), 32'(rd));
      check("alu_writedata", writedata, data);
    end
    check("alu_err", 32'(err), 32'd0);
  endtask

  task automatic do_load(input int lt, input logic [4:0] rd, input logic [31:0] addr,
                         input logic [31:0] word, input logic [31:0] old, input int waits);
    req_valid   = 1'b1;
    req_is_load = 1'b1;
    req_ltype   = 3'(lt);
    req_rd      = rd;
    req_addr    = addr;
    req_old     = old;
    req_alu     = $urandom;
    avm_waitrequest = (waits > 0);
    check("ld_ready_before", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!model_legal(lt, addr)) begin
      check("ld_err_pulse", 32'(err), 32'd1);
      check("ld_err_noread", 32'(avm_read), 32'd0);
      check("ld_err_nowrite", 32'(RegWrite), 32'd0);
      @(posedge clk); #1;
      check("ld_err_cleared", 32'(err), 32'd0);
      check("ld_err_noread2", 32'(avm_read), 32'd0);
      check("ld_err_ready", 32'(req_ready), 32'd1);
      return;
    end
    check("ld_read", 32'(avm_read), 32'd1);
    check("ld_addr", avm_address, addr & 32'hFFFF_FFFC);
    check("ld_be", 32'(avm_byteenable), 32'(model_be(lt, addr)));
    check("ld_ready_busy", 32'(req_ready), 32'd0);
    check("ld_err_none", 32'(err), 32'd0);
    for (int w = 0; w < waits; w++) begin
      avm_waitrequest = 1'b1;
      avm_readdata    = $urandom;
      @(posedge clk); #1;
      check("ld_read_held", 32'(avm_read), 32'd1);
      check("ld_addr_held", avm_address, addr & 32'hFFFF_FFFC);
      check("ld_be_held", 32'(avm_byteenable), 32'(model_be(lt, addr)));
    end
    avm_waitrequest = 1'b0;
    avm_readdata    = word;
    @(posedge clk); #1;
    avm_readdata = $urandom;
    check("ld_read_drop", 32'(avm_read), 32'd0);
    check("ld_no_early_write", 32'(RegWrite), 32'd0);
    @(posedge clk); #1;
    check("ld_regwrite", 32'(RegWrite), 32'(rd != 5'd0));
    if (rd != 5'd0) begin
      check("ld_writer", 32'(writeR), 32'(rd));
      check("ld_writedata", writedata, model_data(lt, addr, word, old));
    end
    check("ld_ready_after", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("ld_write_one_cycle", 32'(RegWrite), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_is_load = 1'b0; req_ltype = 3'd0; req_rd = 5'd0;
    req_addr = 32'h0; req_alu = 32'h0; req_old = 32'h0;
    avm_waitrequest = 1'b0; avm_readdata = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_writer", 32'(writeR), 32'd0);
    check("rst_writedata", writedata, 32'd0);
    check("rst_read", 32'(avm_read), 32'd0);
    check("rst_address", avm_address, 32'd0);
    check("rst_be", 32'(avm_byteenable), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready_after", 32'(req_ready), 32'd1);

    // ALU burst, one write per cycle
    do_alu(5'd1, 32'h11);
    do_alu(5'd2, 32'h22);
    do_alu(5'd3, 32'h33);
    req_valid = 1'b0;
    check("burst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("burst_end", 32'(RegWrite), 32'd0);

    // Directed loads
    do_load(1, 5'd4, 32'h0000_1003, 32'h80FF_0000, 32'h0, 3);
    do_load(4, 5'd5, 32'h0000_2002, 32'hBEEF_1234, 32'h0, 0);
    do_load(0, 5'd6, 32'h0000_3001, 32'h1234_5678, 32'h0, 0);
    do_load(0, 5'd0, 32'h0000_4000, 32'hCAFE_F00D, 32'h0, 1);
    do_load(3, 5'd7, 32'h0000_5002, 32'h8001_7FFF, 32'h0, 0);
    do_load(3, 5'd8, 32'h0000_5003, 32'h8001_7FFF, 32'h0, 0);
    do_load(7, 5'd9, 32'h0000_6000, 32'h0, 32'h0, 0);
    do_load(5, 5'd10, 32'h0000_7001, 32'hAABB_CCDD, 32'h1122_3344, 0);
    do_load(6, 5'd11, 32'h0000_7001, 32'hAABB_CCDD, 32'h1122_3344, 2);
    do_alu(5'd0, 32'hDEAD_BEEF);
    req_valid = 1'b0;

    // Reset while a read is stalled
    req_valid = 1'b1; req_is_load = 1'b1; req_ltype = 3'd0; req_rd = 5'd12;
    req_addr = 32'h0000_8000; avm_waitrequest = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_read_active", 32'(avm_read), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_read_async_drop", 32'(avm_read), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h5555_AAAA;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("mid_read_no_write", 32'(RegWrite), 32'd0);
      check("mid_read_no_read", 32'(avm_read), 32'd0);
    end
    check("mid_read_ready", 32'(req_ready), 32'd1);

    // Randomized mix
    for (int n = 0; n < 60; n++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if ($urandom_range(0, 3) == 0) begin
        do_alu(rd, $urandom);
        req_valid = 1'b0;
      end else begin
        do_load($urandom_range(0, 7), rd, $urandom, $urandom, $urandom,
                $urandom_range(0, 3));
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
